sevenseg_scanner: RTL and testbench
===================================

# sevenseg_scanner

- Downstream consumer of the seven-segment fields of the peripheral control bus.
- Time-multiplexes the eight-digit common-anode display on the board.
- Applies per-digit enable masking and 16-step PWM brightness.
- Frame-synchronous snapshot of data/control: no tearing when software rewrites registers mid-scan.

## Interface

Parameters:
- SUB_DIV, default 6250: clock cycles per brightness sub-phase, minimum 2.
  - Digit slot = 16·SUB_DIV cycles; frame = 128·SUB_DIV cycles (8 ms at 100 MHz).

Ports:
- clk  input  1  system clock; the only clock.
- reset  input  1  synchronous, active-high reset.
- display_control  input  32  control-bus field.
  - [7:0] digit enable mask, bit i = digit i.
  - [11:8] brightness 0–15.
  - [31:12] ignored.
- sevenseg_data  input  64  control-bus field.
  - Byte i = digit i pattern: bit7 = dp, bits 6:0 = segments g..a, 1 = lit.
- anode_n  output  8  digit drivers, active-low, registered.
- cathode_n  output  8  segment drivers, active-low, bit7 = dp, registered.
- frame_tick  output  1  one-cycle pulse at frame start, registered.

## Operation

Counters:
- sub_cnt 0..SUB_DIV-1, increments every cycle.
- phase 0..15, increments when sub_cnt wraps.
- digit 0..7, increments when phase wraps from 15.
- digit wraps 7→0 silently.

Frame start:
- Frame start = cycle with sub_cnt=0, phase=0, digit=0.
- Effective control/data = frame start ? live inputs : shadow registers.
- At frame start, shadow registers load the live inputs.
- Effective values therefore change only at frame boundaries.

Lit condition, evaluated on effective values:
- lit = enable[digit] AND (phase < brightness).
- phase 15 is therefore always dark: built-in anti-ghosting gap at every digit change.
- brightness 0 → display fully dark; brightness 15 → lit 15/16 of each slot.

Outputs, registered every cycle:
- lit: anode_n = ~(1<<digit), cathode_n = ~pattern byte[digit].
- not lit: anode_n = 8'hFF, cathode_n = 8'hFF.
- At most one anode_n bit is ever low.
- frame_tick is registered high for the frame-start cycle, low otherwise.

Reset:
- Reset clears all counters and shadow registers.
- anode_n = 8'hFF, cathode_n = 8'hFF, frame_tick = 0.
- Reset asserted mid-frame aborts the scan.
- The first cycle after release is a frame start; the scan restarts at digit 0 with a fresh snapshot.

## Timing

- Output latency: one cycle. Outputs after edge k reflect the counter state and effective values before edge k.
- frame_tick rises one cycle after the frame-start counter state and lasts exactly one cycle; period 128·SUB_DIV.
- Digit i is lit in the window [16·SUB_DIV·i + 1, 16·SUB_DIV·i + brightness·SUB_DIV] cycles after frame_tick's rising edge cycle − 1, i.e. a contiguous brightness·SUB_DIV cycles at the start of its slot.
- Input changes away from frame start: no output effect until the next frame_tick.
- Input change on the frame-start cycle: visible in that frame.
- No handshake; inputs are sampled, never acknowledged.

## Test plan

Run all scenarios with SUB_DIV=2 (slot 32 cycles, frame 256 cycles).

- Reset held 10 cycles, then released at mid-scan:
  - During reset: anode_n=FF, cathode_n=FF, frame_tick=0.
  - frame_tick pulses one cycle after release.
  - Digit 0 is driven next.
- display_control=0x00000FFF, sevenseg_data byte0=0x3F:
  - Digit 0 slot: anode_n=FE, cathode_n=C0 for 30 cycles, then FF/FF for 2 cycles.
  - Digits 1–7 follow the same 30/2 pattern.
- Brightness 1, mask FF: each digit lit exactly 2 cycles per 32-cycle slot. Brightness 0: anode_n stays FF for 3 frames.
- Mask 0x05, brightness 15: only anode_n patterns FE, FB, FF ever appear.
- Data byte0 changed 0x3F→0x06 at cycle 40 of a frame: digit 0 still shows C0 until after the next frame_tick, then shows F9.
- Check frame_tick period = 256 cycles across 4 frames; no two anode_n bits are ever low simultaneously (assertion, whole run).

Source files
------------

// File: rtl/sevenseg_scanner_if.sv
// Seven-segment fields of the peripheral control bus plus the display drive lines.
// The master side owns the control/data fields; the scanner (slave) owns the drive lines.
interface sevenseg_scanner_if;
   logic [31:0] display_control;
   logic [63:0] sevenseg_data;
   logic [7:0]  anode_n;
   logic [7:0]  cathode_n;
   logic        frame_tick;

   modport master (
      output display_control,
      output sevenseg_data,
      input  anode_n,
      input  cathode_n,
      input  frame_tick
   );

   modport slave (
      input  display_control,
      input  sevenseg_data,
      output anode_n,
      output cathode_n,
      output frame_tick
   );
endinterface

// File: rtl/sevenseg_scanner.sv
// Eight-digit common-anode seven-segment scanner with per-digit enable and 16-step PWM.
// Control and data are snapshotted at each frame start so software rewrites never tear a frame.
module sevenseg_scanner #(
   parameter int unsigned SUB_DIV = 6250
) (
   input logic               clk,
   input logic               reset,
   sevenseg_scanner_if.slave bus
);

   localparam int unsigned     SubW    = $clog2(SUB_DIV);
   localparam logic [SubW-1:0] SubLast = SubW'(SUB_DIV - 1);

   if (SUB_DIV < 2) begin : g_bad_sub_div
      $error("sevenseg_scanner: SUB_DIV must be at least 2");
   end

   logic [SubW-1:0] sub_cnt_q, sub_cnt_d;
   logic [3:0]      phase_q, phase_d;
   logic [2:0]      digit_q, digit_d;
   logic [11:0]     ctrl_q, ctrl_d;
   logic [63:0]     data_q, data_d;
   logic [7:0]      anode_n_q, anode_n_d;
   logic [7:0]      cathode_n_q, cathode_n_d;
   logic            frame_tick_q, frame_tick_d;

   logic            frame_start;
   logic            sub_wrap;
   logic            lit;
   logic [11:0]     eff_ctrl;
   logic [63:0]     eff_data;

   // Upper control bits carry nothing for this block.
   logic unused_ctrl_bits;
   assign unused_ctrl_bits = ^bus.display_control[31:12];

   // Scan counters, frame snapshot and next output values.
   always_comb begin
      frame_start = (sub_cnt_q == '0) && (phase_q == 4'd0) && (digit_q == 3'd0);

      // On the frame-start cycle the live bus is used directly, so a write landing
      // exactly there is visible in the frame it starts.
      eff_ctrl = frame_start ? bus.display_control[11:0] : ctrl_q;
      eff_data = frame_start ? bus.sevenseg_data : data_q;
      ctrl_d   = eff_ctrl;
      data_d   = eff_data;

      sub_wrap  = (sub_cnt_q == SubLast);
      sub_cnt_d = sub_wrap ? '0 : sub_cnt_q + SubW'(1);
      phase_d   = sub_wrap ? phase_q + 4'd1 : phase_q;
      digit_d   = (sub_wrap && (phase_q == 4'd15)) ? digit_q + 3'd1 : digit_q;

      // phase 15 can never satisfy phase < brightness, giving a dark gap before each digit change.
      lit = eff_ctrl[digit_q] && (phase_q < eff_ctrl[11:8]);

      anode_n_d    = lit ? ~(8'd1 << digit_q) : 8'hFF;
      cathode_n_d  = lit ? ~eff_data[{digit_q, 3'b000} +: 8] : 8'hFF;
      frame_tick_d = frame_start;
   end

   // State and registered outputs, synchronous reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         sub_cnt_q    <= '0;
         phase_q      <= 4'd0;
         digit_q      <= 3'd0;
         ctrl_q       <= 12'd0;
         data_q       <= 64'd0;
         anode_n_q    <= 8'hFF;
         cathode_n_q  <= 8'hFF;
         frame_tick_q <= 1'b0;
      end else begin
         sub_cnt_q    <= sub_cnt_d;
         phase_q      <= phase_d;
         digit_q      <= digit_d;
         ctrl_q       <= ctrl_d;
         data_q       <= data_d;
         anode_n_q    <= anode_n_d;
         cathode_n_q  <= cathode_n_d;
         frame_tick_q <= frame_tick_d;
      end
   end

   assign bus.anode_n    = anode_n_q;
   assign bus.cathode_n  = cathode_n_q;
   assign bus.frame_tick = frame_tick_q;

endmodule

// File: tb/tb_sevenseg_scanner.sv
// Bench for sevenseg_scanner: directed scenarios plus random bus writes, checked every cycle
// against a frame-position reference model.
module tb_sevenseg_scanner;

   localparam int unsigned SubDiv = 2;
   localparam int unsigned Slot   = 16 * SubDiv;
   localparam int unsigned Frame  = 128 * SubDiv;

   logic clk = 1'b0;
   logic reset;

   always #5 clk = ~clk;

   sevenseg_scanner_if bus ();

   sevenseg_scanner #(
      .SUB_DIV(SubDiv)
   ) dut (
      .clk  (clk),
      .reset(reset),
      .bus  (bus)
   );

   int total = 0;
   int bad   = 0;

   // Reference model state: position within the frame of the next cycle, and the frame snapshot.
   int          pos = 0;
   logic [11:0] m_ctrl;
   logic [63:0] m_data;
   int          cyc = 0;

   // Observed statistics, cleared per scenario.
   int lit_cnt[8];
   int any_lit, odd_cnt, c0_cnt, f9_cnt;
   int ft_q[$];

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp)
      else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic clear_stats();
      for (int i = 0; i < 8; i++) lit_cnt[i] = 0;
      any_lit = 0;
      odd_cnt = 0;
      c0_cnt  = 0;
      f9_cnt  = 0;
      ft_q.delete();
   endtask

   // One clock: predict from inputs as they stand, advance, then compare.
   task automatic step();
      logic [7:0] ea, ec;
      logic       ef;
      int         d, ph;
      ea = 8'hFF;
      ec = 8'hFF;
      ef = 1'b0;
      if (reset) begin
         pos    = 0;
         m_ctrl = '0;
         m_data = '0;
      end else begin
         if (pos == 0) begin
            m_ctrl = bus.display_control[11:0];
            m_data = bus.sevenseg_data;
         end
         d  = pos / Slot;
         ph = (pos % Slot) / SubDiv;
         ef = (pos == 0);
         if (m_ctrl[d] && (ph < int'(m_ctrl[11:8]))) begin
            ea = ~(8'd1 << d);
            ec = ~m_data[d*8 +: 8];
         end
         pos = (pos + 1) % Frame;
      end
      @(posedge clk);
      #1;
      cyc++;
      check("anode_n", 64'(bus.anode_n), 64'(ea));
      check("cathode_n", 64'(bus.cathode_n), 64'(ec));
      check("frame_tick", 64'(bus.frame_tick), 64'(ef));
      for (int i = 0; i < 8; i++) if (bus.anode_n == ~(8'd1 << i)) lit_cnt[i]++;
      if (bus.anode_n != 8'hFF) any_lit++;
      if (!(bus.anode_n inside {8'hFE, 8'hFB, 8'hFF})) odd_cnt++;
      if (bus.anode_n == 8'hFE && bus.cathode_n == 8'hC0) c0_cnt++;
      if (bus.anode_n == 8'hFE && bus.cathode_n == 8'hF9) f9_cnt++;
      if (bus.frame_tick) ft_q.push_back(cyc);
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) step();
   endtask

   // At most one digit driven at any time, whole run.
   always @(negedge clk) begin
      if (cyc > 0) begin
         total++;
         assert ($countones(~bus.anode_n) <= 1)
         else begin
            bad++;
            $error("FAIL anode_onehot observed=%0h expected=at_most_one_low", bus.anode_n);
         end
      end
   end

   initial begin
      logic [63:0] d64;
      reset                = 1'b1;
      bus.display_control  = 32'h0000_0FFF;
      d64                  = {$urandom, $urandom};
      bus.sevenseg_data    = {d64[63:8], 8'h3F};
      clear_stats();

      // Start, run into the middle of a scan, then reset for 10 cycles.
      run(2);
      reset = 1'b0;
      run(100);
      reset = 1'b1;
      run(10);
      reset = 1'b0;

      // First cycle after release: frame tick and digit 0.
      clear_stats();
      step();
      check("ft_after_release", 64'(bus.frame_tick), 64'd1);
      check("digit0_after_release", 64'(bus.anode_n), 64'hFE);
      run(Frame - 1);
      for (int i = 0; i < 8; i++) check($sformatf("lit_b15_d%0d", i), 64'(lit_cnt[i]), 64'(15 * SubDiv));
      check("digit0_c0_cycles", 64'(c0_cnt), 64'(15 * SubDiv));
      check("ticks_per_frame", 64'(ft_q.size()), 64'd1);

      // Brightness 1, all digits enabled.
      bus.display_control = 32'h0000_01FF;
      clear_stats();
      run(Frame);
      for (int i = 0; i < 8; i++) check($sformatf("lit_b1_d%0d", i), 64'(lit_cnt[i]), 64'(SubDiv));

      // Brightness 0: dark for 3 frames.
      bus.display_control = 32'h0000_00FF;
      clear_stats();
      run(3 * Frame);
      check("dark_b0", 64'(any_lit), 64'd0);

      // Mask 0x05, brightness 15.
      bus.display_control = 32'h0000_0F05;
      clear_stats();
      run(Frame);
      check("mask05_patterns", 64'(odd_cnt), 64'd0);
      check("mask05_d0", 64'(lit_cnt[0]), 64'(15 * SubDiv));
      check("mask05_d2", 64'(lit_cnt[2]), 64'(15 * SubDiv));
      check("mask05_d1", 64'(lit_cnt[1]), 64'd0);

      // Mid-frame data rewrite is held off until the next frame.
      bus.display_control = 32'h0000_0FFF;
      clear_stats();
      run(40);
      bus.sevenseg_data = {bus.sevenseg_data[63:8], 8'h06};
      run(Frame - 40);
      check("old_pattern_kept", 64'(c0_cnt), 64'(15 * SubDiv));
      check("new_pattern_held", 64'(f9_cnt), 64'd0);
      clear_stats();
      run(Frame);
      check("new_pattern_shown", 64'(f9_cnt), 64'(15 * SubDiv));
      check("old_pattern_gone", 64'(c0_cnt), 64'd0);

      // Frame tick period across 4 frames.
      clear_stats();
      run(4 * Frame);
      check("tick_count_4f", 64'(ft_q.size()), 64'd4);
      for (int i = 1; i < ft_q.size(); i++)
         check($sformatf("tick_period_%0d", i), 64'(ft_q[i] - ft_q[i-1]), 64'(Frame));

      // Random writes at arbitrary cycles plus one mid-frame reset.
      for (int k = 0; k < 8 * Frame; k++) begin
         if ($urandom_range(63) == 0) bus.display_control = $urandom;
         if ($urandom_range(63) == 0) bus.sevenseg_data = {$urandom, $urandom};
         if (pos == 0 && $urandom_range(3) == 0) bus.display_control = $urandom;
         if (k == 1000) begin
            reset = 1'b1;
            run(int'($urandom_range(1, 5)));
            reset = 1'b0;
         end
         step();
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
